// File: rtl/xilinx_board_io.sv
// ---------------------------------------------------------------------------
// xilinx_board_io
//
// Board I/O conditioner for the FPGA top level. Raw buttons and switches are
// synchronised and debounced into clean levels plus one-cycle rise/fall
// pulses. Every LED is driven by a glitch-free PWM brightness generator.
//
// Configuration macro: BOARD_IO_PWM_EN
//   defined   - free-running PWM counter with per-LED duty shadows.
//   undefined - no PWM hardware; led_o[i] is simply (duty slice != 0),
//               registered once.
//
// Ports:
//   sys_clk      in   1               single clock for the whole block
//   pad_reset_n  in   1               synchronous active-low reset
//   in_raw_i     in   NUM_IN          raw asynchronous board inputs
//   in_level_o   out  NUM_IN          debounced level
//   in_rise_o    out  NUM_IN          one-cycle pulse on accepted 0->1
//   in_fall_o    out  NUM_IN          one-cycle pulse on accepted 1->0
//   tick_o       out  1               debounce prescaler tick
//   led_duty_i   in   NUM_LED*PWM_W   per-LED duty, LED i at [i*PWM_W +: PWM_W]
//   led_o        out  NUM_LED         LED drive
// ---------------------------------------------------------------------------
module xilinx_board_io #(
  parameter int NUM_IN         = 7,
  parameter int NUM_LED        = 4,
  parameter int PRESCALE       = 1000,
  parameter int DEBOUNCE_TICKS = 16,
  parameter int PWM_W          = 8
) (
  input  logic                       sys_clk,
  input  logic                       pad_reset_n,
  input  logic [NUM_IN-1:0]          in_raw_i,
  output logic [NUM_IN-1:0]          in_level_o,
  output logic [NUM_IN-1:0]          in_rise_o,
  output logic [NUM_IN-1:0]          in_fall_o,
  output logic                       tick_o,
  input  logic [NUM_LED*PWM_W-1:0]   led_duty_i,
  output logic [NUM_LED-1:0]         led_o
);

  localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS) + 1;

  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [NUM_IN-1:0]  r_s1;
  logic [NUM_IN-1:0]  r_s2;
  logic [PS_W-1:0]    r_presc;
  logic [PS_W-1:0]    w_presc_nxt;
  logic               r_tick;
  logic [CNT_W-1:0]   r_cnt [NUM_IN];
  logic [NUM_IN-1:0]  r_level;
  logic [NUM_IN-1:0]  r_rise;
  logic [NUM_IN-1:0]  r_fall;
  logic [NUM_LED-1:0] r_led;

  // Two-flop synchroniser per raw input.
  always_ff @(posedge sys_clk) begin
    if (!pad_reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_raw_i;
      r_s2 <= r_s1;
    end
  end

  // Prescaler. The tick is registered from the next count value so that it
  // is high exactly while r_presc sits at PRESCALE-1, yet stays 0 during
  // reset even when PRESCALE=1 (where the count is permanently 0).
  assign w_presc_nxt = (r_presc == PS_LAST) ? '0 : r_presc + PS_W'(1);

  always_ff @(posedge sys_clk) begin
    if (!pad_reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_nxt;
      r_tick  <= (w_presc_nxt == PS_LAST);
    end
  end

  // Debounce. A disagreeing synchronised input must persist for
  // DEBOUNCE_TICKS ticks before the level follows it; agreement clears the
  // counter every cycle so any bounce restarts qualification. Acceptance is
  // held off for one cycle after a pulse so two pulses can never be adjacent
  // (only reachable with DEBOUNCE_TICKS=1 and a fast toggle).
  always_ff @(posedge sys_clk) begin
    if (!pad_reset_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        r_cnt[i] <= '0;
      end
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_s2[i] == r_level[i]) begin
          r_cnt[i] <= '0;
        end else if (r_tick && !(r_rise[i] || r_fall[i])) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_level[i] <= r_s2[i];
            r_cnt[i]   <= '0;
            r_rise[i]  <= r_s2[i];
            r_fall[i]  <= ~r_s2[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

`ifdef BOARD_IO_PWM_EN
  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic [PWM_W-1:0] r_pwm_cnt;
  logic [PWM_W-1:0] r_shadow [NUM_LED];

  // PWM. The shadow is written on the edge where the counter wraps, so it
  // already holds the new duty throughout the pwm_cnt==0 cycle and for the
  // whole period that follows; mid-period duty writes therefore never
  // produce a truncated or stretched pulse. Shadow all-ones means fully on.
  always_ff @(posedge sys_clk) begin
    if (!pad_reset_n) begin
      r_pwm_cnt <= '0;
      for (int i = 0; i < NUM_LED; i++) begin
        r_shadow[i] <= '0;
      end
      r_led <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      for (int i = 0; i < NUM_LED; i++) begin
        if (r_pwm_cnt == PWM_MAX) begin
          r_shadow[i] <= led_duty_i[i*PWM_W +: PWM_W];
        end
        r_led[i] <= (r_shadow[i] == PWM_MAX) || (r_pwm_cnt < r_shadow[i]);
      end
    end
  end
`else
  // No dimming hardware: any non-zero duty turns the LED fully on.
  always_ff @(posedge sys_clk) begin
    if (!pad_reset_n) begin
      r_led <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        r_led[i] <= (led_duty_i[i*PWM_W +: PWM_W] != '0);
      end
    end
  end
`endif

  assign in_level_o = r_level;
  assign in_rise_o  = r_rise;
  assign in_fall_o  = r_fall;
  assign tick_o     = r_tick;
  assign led_o      = r_led;

endmodule

// File: tb/tb_xilinx_board_io.sv
// ---------------------------------------------------------------------------
// tb_xilinx_board_io
//
// Self-checking bench for xilinx_board_io. Main instance: NUM_IN=7,
// NUM_LED=4, PRESCALE=1, DEBOUNCE_TICKS=4, PWM_W=8. A second instance with
// PRESCALE=10, DEBOUNCE_TICKS=3 exercises the prescaler. Expected debounce
// events are queued by the stimulus side and consumed by a monitor whenever
// the DUT raises a rise/fall pulse. LED expectations follow the build macro
// BOARD_IO_PWM_EN.
// ---------------------------------------------------------------------------
module tb_xilinx_board_io;

  localparam int NUM_IN   = 7;
  localparam int NUM_LED  = 4;
  localparam int PWM_W    = 8;
  localparam int DEB      = 4;
  // With PRESCALE=1 the level changes DEB+1 edges after the first sampling
  // edge, which itself is one edge after the stimulus negedge.
  localparam int EVT_LAT  = 1 + DEB + 1;

`ifdef BOARD_IO_PWM_EN
  localparam int EXP_FIRST [4] = '{0, 0, 0, 0};
  localparam int EXP_STEADY[4] = '{0, 64, 256, 128};
  localparam logic [7:0] MID_DUTY = 8'd16;
  localparam int EXP_MID_A = 0;
  localparam int EXP_MID_B = 16;
`else
  localparam int EXP_FIRST [4] = '{0, 251, 251, 251};
  localparam int EXP_STEADY[4] = '{0, 256, 256, 256};
  localparam logic [7:0] MID_DUTY = 8'h01;
  localparam int EXP_MID_A = 156;
  localparam int EXP_MID_B = 256;
`endif

  logic                     clk;
  logic                     resetN;
  logic [NUM_IN-1:0]        rawIn;
  logic [NUM_IN-1:0]        levelOut;
  logic [NUM_IN-1:0]        riseOut;
  logic [NUM_IN-1:0]        fallOut;
  logic                     tickOut;
  logic [NUM_LED*PWM_W-1:0] dutyIn;
  logic [NUM_LED-1:0]       ledOut;

  logic [0:0] rawPs;
  logic [0:0] levelPs;
  logic [0:0] risePs;
  logic [0:0] fallPs;
  logic       tickPs;
  logic [7:0] dutyPs;
  logic [0:0] ledPs;

  int cyc;
  int checks;
  int failures;
  int rRel;
  int ledCount [4];

  typedef struct {
    int               cyc;
    logic [NUM_IN-1:0] rise;
    logic [NUM_IN-1:0] fall;
    logic [NUM_IN-1:0] level;
  } event_t;

  event_t sbQueue[$];

  xilinx_board_io #(
    .NUM_IN(NUM_IN), .NUM_LED(NUM_LED), .PRESCALE(1),
    .DEBOUNCE_TICKS(DEB), .PWM_W(PWM_W)
  ) dut (
    .sys_clk(clk), .pad_reset_n(resetN), .in_raw_i(rawIn),
    .in_level_o(levelOut), .in_rise_o(riseOut), .in_fall_o(fallOut),
    .tick_o(tickOut), .led_duty_i(dutyIn), .led_o(ledOut)
  );

  xilinx_board_io #(
    .NUM_IN(1), .NUM_LED(1), .PRESCALE(10),
    .DEBOUNCE_TICKS(3), .PWM_W(8)
  ) dutPs (
    .sys_clk(clk), .pad_reset_n(resetN), .in_raw_i(rawPs),
    .in_level_o(levelPs), .in_rise_o(risePs), .in_fall_o(fallPs),
    .tick_o(tickPs), .led_duty_i(dutyPs), .led_o(ledPs)
  );

  // Free-running clock and posedge counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Safety net in case a wait never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive the raw inputs at the next negedge, optionally queueing the
  // debounce event that should result.
  task automatic applyStimulus(input logic [NUM_IN-1:0] raw, input bit expectEvent,
                               input logic [NUM_IN-1:0] expRise,
                               input logic [NUM_IN-1:0] expFall,
                               input logic [NUM_IN-1:0] expLevel);
    event_t e;
    @(negedge clk);
    rawIn = raw;
    if (expectEvent) begin
      e.cyc   = cyc + EVT_LAT;
      e.rise  = expRise;
      e.fall  = expFall;
      e.level = expLevel;
      sbQueue.push_back(e);
    end
  endtask

  // Advance to the negedge following post-release edge n.
  task automatic waitRel(input int n);
    while (cyc - rRel < n) @(negedge clk);
  endtask

  task automatic countLeds(input int firstN, input int lastN);
    for (int i = 0; i < 4; i++) ledCount[i] = 0;
    for (int n = firstN; n <= lastN; n++) begin
      waitRel(n);
      for (int i = 0; i < 4; i++) ledCount[i] += int'(ledOut[i]);
    end
  endtask

  // Scoreboard monitor: every rise/fall pulse must match the head of the
  // expected-event queue, including the exact cycle.
  initial begin : monitor
    logic [NUM_IN-1:0] pulse;
    logic [NUM_IN-1:0] prevPulse;
    event_t exp;
    prevPulse = '0;
    forever begin
      @(negedge clk);
      pulse = riseOut | fallOut;
      if (pulse != '0) begin
        if (sbQueue.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedEvent: got rise=%h fall=%h at cycle %0d, expected no event",
                   riseOut, fallOut, cyc);
        end else begin
          exp = sbQueue.pop_front();
          checkOutput("eventCycle", cyc, exp.cyc);
          checkOutput("eventRise", 32'(riseOut), 32'(exp.rise));
          checkOutput("eventFall", 32'(fallOut), 32'(exp.fall));
          checkOutput("eventLevel", 32'(levelOut), 32'(exp.level));
        end
        checkOutput("riseFallExclusive", 32'(riseOut & fallOut), 32'd0);
        checkOutput("noBackToBack", 32'(pulse & prevPulse), 32'd0);
      end
      prevPulse = pulse;
    end
  end

  initial begin : stimulus
    event_t e;
    int     found;
    int     latency;
    int     tickCount;
    int     stepCyc;

    checks   = 0;
    failures = 0;
    rRel     = 0;
    resetN   = 1'b0;
    rawIn    = 7'h7F;
    dutyIn   = {8'd128, 8'd255, 8'd64, 8'd0};
    rawPs    = 1'b0;
    dutyPs   = 8'h00;

    // Reset with all inputs held high: everything must read 0.
    waitCycles(4);
    checkOutput("resetLevel", 32'(levelOut), 32'd0);
    checkOutput("resetRise", 32'(riseOut), 32'd0);
    checkOutput("resetFall", 32'(fallOut), 32'd0);
    checkOutput("resetTick", 32'(tickOut), 32'd0);
    checkOutput("resetLed", 32'(ledOut), 32'd0);
    checkOutput("resetTickPs", 32'(tickPs), 32'd0);
    checkOutput("resetLevelPs", 32'(levelPs), 32'd0);

    resetN  = 1'b1;
    e.cyc   = cyc + EVT_LAT;
    e.rise  = 7'h7F;
    e.fall  = 7'h00;
    e.level = 7'h7F;
    sbQueue.push_back(e);
    waitCycles(1);
    checkOutput("tickAfterReset", 32'(tickOut), 32'd1);
    waitCycles(9);
    checkOutput("levelAfterResetRise", 32'(levelOut), 32'h7F);
    checkOutput("tickSteady", 32'(tickOut), 32'd1);

    // Clean fall on input 0, then a bouncy rise that must be accepted once.
    applyStimulus(7'h7E, 1'b1, 7'h00, 7'h01, 7'h7E);
    waitCycles(10);
    checkOutput("levelAfterFall", 32'(levelOut), 32'h7E);
    applyStimulus(7'h7F, 1'b0, '0, '0, '0);
    waitCycles(1);
    applyStimulus(7'h7E, 1'b0, '0, '0, '0);
    waitCycles(1);
    applyStimulus(7'h7F, 1'b1, 7'h01, 7'h00, 7'h7F);
    waitCycles(3);
    checkOutput("levelDuringQualify", 32'(levelOut), 32'h7E);
    waitCycles(8);
    checkOutput("levelAfterBounce", 32'(levelOut), 32'h7F);

    // Fresh reset with inputs low, then reset in the middle of a pending rise.
    @(negedge clk);
    resetN = 1'b0;
    rawIn  = 7'h00;
    waitCycles(3);
    resetN = 1'b1;
    waitCycles(8);
    checkOutput("levelCleanStart", 32'(levelOut), 32'd0);
    applyStimulus(7'h04, 1'b0, '0, '0, '0);
    waitCycles(4);
    resetN = 1'b0;
    checkOutput("levelAtMidReset", 32'(levelOut), 32'd0);
    waitCycles(3);
    checkOutput("levelInMidReset", 32'(levelOut), 32'd0);
    checkOutput("riseInMidReset", 32'(riseOut), 32'd0);
    resetN  = 1'b1;
    rRel    = cyc;
    e.cyc   = cyc + EVT_LAT;
    e.rise  = 7'h04;
    e.fall  = 7'h00;
    e.level = 7'h04;
    sbQueue.push_back(e);
    waitRel(5);
    checkOutput("levelRequalifying", 32'(levelOut), 32'd0);

    // LEDs: first period after release, then a steady period.
    countLeds(6, 256);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("ledFirstPeriod%0d", i), ledCount[i], EXP_FIRST[i]);
    countLeds(513, 768);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("ledSteady%0d", i), ledCount[i], EXP_STEADY[i]);

    // Mid-period duty change on LED 0.
    waitRel(868);
    checkOutput("led0BeforeChange", 32'(ledOut[0]), 32'd0);
    dutyIn[7:0] = MID_DUTY;
    countLeds(869, 1024);
    checkOutput("led0RestOfPeriod", ledCount[0], EXP_MID_A);
    countLeds(1025, 1280);
    checkOutput("led0NextPeriod", ledCount[0], EXP_MID_B);

    // Prescaler instance: one tick every 10 cycles, bounded step latency.
    tickCount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tickCount += int'(tickPs);
    end
    checkOutput("psTickCount", tickCount, 10);

    @(negedge clk);
    rawPs   = 1'b1;
    stepCyc = cyc + 1;
    found   = 0;
    latency = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (levelPs == 1'b1) begin
        found   = 1;
        latency = cyc - stepCyc;
        checkOutput("psRiseWithLevel", 32'(risePs), 32'd1);
      end
    end
    checkOutput("psLevelAccepted", found, 1);
    checkOutput("psLatencyInRange", 32'((latency >= 22) && (latency <= 31)), 32'd1);
    if (found == 1 && !((latency >= 22) && (latency <= 31)))
      $display("[TB] psLatency measured %0d edges", latency);

    waitCycles(4);
    checkOutput("scoreboardEmpty", sbQueue.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
